// File: rtl/seg_scan_ctrl_if.sv
// Update port bundle for seg_scan_ctrl: valid/ready transfer of
// NUM_DIGITS hex nibbles plus per-digit decimal points.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [4*NUM_DIGITS-1:0] upd_digits;
  logic [NUM_DIGITS-1:0]   upd_dp;

  modport master (
    output upd_valid,
    output upd_digits,
    output upd_dp,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_digits,
    input  upd_dp,
    output upd_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking gaps,
// tear-free shadow update and optional leading-zero blanking.
// Ports: clk, rst (sync, active-high), enable_i, lzb_en_i,
// upd (slave update port), segments_o[6:0] (a..g), dp_o,
// digit_en_o (one-hot), frame_done_o (1-cycle pulse).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  lzb_en_i,
  seg_scan_ctrl_if.slave        upd,
  output logic [6:0]            segments_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] digit_en_o,
  output logic                  frame_done_o
);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DW-1:0]         shadow_q, pend_q;
  logic [NUM_DIGITS-1:0] shdp_q, pdp_q;
  logic                  rdy_q, rdy_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q, fd_d;
  logic                  move, xfer;
  logic [NUM_DIGITS-1:0] blank;
  logic                  seen;
  logic [3:0]            nib;

  assign xfer = upd.upd_valid & rdy_q;

  // Scan sequencer; move marks the pending->shadow copy point
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    fd_d    = 1'b0;
    move    = 1'b0;
    case (state_q)
      S_IDLE: begin
        move = ~rdy_q;
        if (enable_i) begin
          state_d = S_BLANK;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      S_BLANK: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end else if (timer_q == BLANK_LAST) begin
          state_d = S_DWELL;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DWELL: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end else if (timer_q == DWELL_LAST) begin
          state_d = S_BLANK;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            fd_d  = 1'b1;
            move  = ~rdy_q;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // Ready drops on accept, returns once pending is copied out
  always_comb begin
    rdy_d = rdy_q;
    if (xfer)      rdy_d = 1'b0;
    else if (move) rdy_d = 1'b1;
  end

  // Zero digits above the most significant nonzero one are blanked
  always_comb begin
    blank = '0;
    seen  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen     = seen | (shadow_q[4*i +: 4] != 4'h0);
      blank[i] = lzb_en_i & ~seen;
    end
  end

  // Outputs are computed from next state so they register in step
  always_comb begin
    nib   = shadow_q[4*idx_d +: 4];
    seg_d = '0;
    dp_d  = 1'b0;
    en_d  = '0;
    if (state_d == S_DWELL) begin
      en_d  = NUM_DIGITS'(1) << idx_d;
      dp_d  = shdp_q[idx_d];
      seg_d = blank[idx_d] ? 7'h00 : hex7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      shdp_q   <= '0;
      pend_q   <= '0;
      pdp_q    <= '0;
      rdy_q    <= 1'b1;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      en_q     <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rdy_q   <= rdy_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      if (move) begin
        shadow_q <= pend_q;
        shdp_q   <= pdp_q;
      end
      if (xfer) begin
        pend_q <= upd.upd_digits;
        pdp_q  <= upd.upd_dp;
      end
    end
  end

  assign upd.upd_ready = rdy_q;
  assign segments_o    = seg_q;
  assign dp_o          = dp_q;
  assign digit_en_o    = en_q;
  assign frame_done_o  = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-position
// reference model with randomized updates and lzb toggling.
module tb_seg_scan_ctrl;
  localparam int ND  = 4;
  localparam int DWC = 4;
  localparam int BLC = 2;
  localparam int PH  = BLC + DWC;
  localparam int PER = ND * PH;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic lzb_en = 1'b0;
  logic [6:0]    segments;
  logic          dp;
  logic [ND-1:0] digit_en;
  logic          frame_done;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) upd ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWC),
    .BLANK_CYCLES(BLC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .lzb_en_i    (lzb_en),
    .upd         (upd),
    .segments_o  (segments),
    .dp_o        (dp),
    .digit_en_o  (digit_en),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int errors = 0;
  int checks = 0;

  logic [15:0] m_sh;
  logic [3:0]  m_shdp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_full;
  int          m_c;
  req_t        rq[$];

  // Expected display at cycle c after enable, from frame position
  function automatic void exp_out(
    input  int         c,
    output logic [6:0] s,
    output logic [3:0] e,
    output logic       d,
    output logic       f
  );
    int p, dg, w;
    logic [15:0] upper;
    p  = c % PER;
    dg = p / PH;
    w  = p % PH;
    s  = 7'h00;
    e  = 4'h0;
    d  = 1'b0;
    f  = (c >= PER) && (p == 0);
    if (w >= BLC) begin
      e     = 4'(1 << dg);
      d     = m_shdp[dg];
      upper = m_sh >> (4 * dg);
      if (lzb_en && dg > 0 && upper == 16'h0) s = 7'h00;
      else s = hex_tab[upper[3:0]];
    end
  endfunction

  task automatic check_cycle();
    logic [6:0] es;
    logic [3:0] ee;
    logic       ed, ef;
    exp_out(m_c, es, ee, ed, ef);
    checks++;
    if ({segments, digit_en, dp, frame_done} !== {es, ee, ed, ef}) begin
      errors++;
      $display("FAIL scan c=%0d: got seg=%h en=%b dp=%b fd=%b want seg=%h en=%b dp=%b fd=%b",
               m_c, segments, digit_en, dp, frame_done, es, ee, ed, ef);
    end
    checks++;
    if (upd.upd_ready !== !m_full) begin
      errors++;
      $display("FAIL ready c=%0d: got %b want %b", m_c, upd.upd_ready, !m_full);
    end
  endtask

  // One enabled cycle: check, drive, advance model, next negedge
  task automatic scan_cycle(input int p_req, input int p_lzb);
    logic mv, xf;
    check_cycle();
    if (p_lzb > 0 && $urandom_range(p_lzb - 1, 0) == 0) lzb_en = ~lzb_en;
    if (p_req > 0 && rq.size() < 2 && $urandom_range(p_req - 1, 0) == 0)
      rq.push_back('{v: 16'($urandom), d: 4'($urandom)});
    upd.upd_valid = (rq.size() > 0);
    if (rq.size() > 0) begin
      upd.upd_digits = rq[0].v;
      upd.upd_dp     = rq[0].d;
    end
    mv = m_full && (m_c % PER == PER - 1);
    xf = upd.upd_valid && !m_full;
    if (mv) begin
      m_sh   = m_pend;
      m_shdp = m_pdp;
    end
    if (xf) begin
      m_pend = rq[0].v;
      m_pdp  = rq[0].d;
      m_full = 1'b1;
      void'(rq.pop_front());
    end else if (mv) begin
      m_full = 1'b0;
    end
    m_c++;
    @(negedge clk);
  endtask

  task automatic check_off(input string tag);
    checks++;
    if ({segments, dp, digit_en, frame_done} !== 12'h000) begin
      errors++;
      $display("FAIL %s: got seg=%h dp=%b en=%b fd=%b want all 0",
               tag, segments, dp, digit_en, frame_done);
    end
  endtask

  task automatic start_scan();
    enable = 1'b1;
    m_c = 0;
    @(negedge clk);
  endtask

  // Drain outstanding updates while scanning, then drop enable
  task automatic go_idle();
    int n;
    n = 0;
    while ((rq.size() > 0 || m_full) && n < 4 * PER) begin
      scan_cycle(0, 0);
      n++;
    end
    checks++;
    if (rq.size() > 0 || m_full) begin
      errors++;
      $display("FAIL drain: got pending=%b queued=%0d want empty", m_full, rq.size());
    end
    enable = 1'b0;
    upd.upd_valid = 1'b0;
    @(negedge clk);
    check_off("idle_entry");
  endtask

  task automatic idle_update(input logic [15:0] v, input logic [3:0] d);
    upd.upd_valid  = 1'b1;
    upd.upd_digits = v;
    upd.upd_dp     = d;
    @(negedge clk);
    upd.upd_valid = 1'b0;
    checks++;
    if (upd.upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_low: got %b want 0", upd.upd_ready);
    end
    @(negedge clk);
    checks++;
    if (upd.upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready_back: got %b want 1", upd.upd_ready);
    end
    check_off("idle_upd_off");
    m_sh   = v;
    m_shdp = d;
    m_full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enable         = 1'($urandom);
      lzb_en         = 1'($urandom);
      upd.upd_valid  = 1'($urandom);
      upd.upd_digits = 16'($urandom);
      upd.upd_dp     = 4'($urandom);
      @(negedge clk);
      check_off("reset_out");
      checks++;
      if (upd.upd_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready: got %b want 1", upd.upd_ready);
      end
    end
    rst = 1'b0;
    enable = 1'b0;
    lzb_en = 1'b0;
    upd.upd_valid = 1'b0;
    m_sh = '0;
    m_shdp = '0;
    m_full = 1'b0;
    @(negedge clk);
    check_off("post_reset");
  endtask

  task automatic test_basic();
    idle_update(16'h1234, 4'b0000);
    start_scan();
    for (int i = 0; i < 2 * PER + 1; i++) begin
      if (m_c == 2) begin
        checks++;
        if (segments !== 7'h66 || digit_en !== 4'b0001) begin
          errors++;
          $display("FAIL basic_first: got seg=%h en=%b want 66/0001", segments, digit_en);
        end
      end
      scan_cycle(0, 0);
    end
    go_idle();
  endtask

  task automatic test_lzb();
    idle_update(16'h0070, 4'b0101);
    lzb_en = 1'b1;
    start_scan();
    for (int i = 0; i < 2 * PER; i++) begin
      if (m_c == PER) lzb_en = 1'b0;
      if (m_c == 20) begin
        checks++;
        if (segments !== 7'h00 || digit_en !== 4'b1000) begin
          errors++;
          $display("FAIL lzb_blank: got seg=%h en=%b want 00/1000", segments, digit_en);
        end
      end
      if (m_c == PER + 20) begin
        checks++;
        if (segments !== 7'h3F) begin
          errors++;
          $display("FAIL lzb_off: got seg=%h want 3F", segments);
        end
      end
      scan_cycle(0, 0);
    end
    go_idle();
  endtask

  task automatic test_midframe();
    idle_update(16'h5678, 4'b0000);
    start_scan();
    for (int i = 0; i < 3 * PER; i++) begin
      if (m_c == 5) rq.push_back('{v: 16'hABCD, d: 4'($urandom)});
      if (m_c == 7) rq.push_back('{v: 16'($urandom), d: 4'($urandom)});
      if (m_c == PER + 2) begin
        checks++;
        if (segments !== 7'h5E) begin
          errors++;
          $display("FAIL mid_new: got seg=%h want 5E", segments);
        end
      end
      scan_cycle(0, 0);
    end
    go_idle();
  endtask

  task automatic test_disable();
    idle_update(16'h9A0F, 4'b1001);
    start_scan();
    for (int i = 0; i < 15; i++) scan_cycle(0, 0);
    check_cycle();
    checks++;
    if (digit_en !== 4'b0100) begin
      errors++;
      $display("FAIL dis_digit2: got en=%b want 0100", digit_en);
    end
    enable = 1'b0;
    @(negedge clk);
    check_off("dis_next");
    @(negedge clk);
    check_off("dis_idle");
    start_scan();
    for (int i = 0; i < 23; i++) scan_cycle(0, 0);
    check_cycle();
    enable = 1'b0;
    @(negedge clk);
    check_off("dis_last_nofd");
    start_scan();
    for (int i = 0; i < PER + 1; i++) scan_cycle(0, 0);
    go_idle();
  endtask

  task automatic test_reset_mid();
    idle_update(16'h1234, 4'b0010);
    start_scan();
    rq.push_back('{v: 16'hBEEF, d: 4'b1111});
    for (int i = 0; i < 10; i++) scan_cycle(0, 0);
    rst = 1'b1;
    upd.upd_valid = 1'b1;
    upd.upd_digits = 16'h7777;
    @(negedge clk);
    check_off("rst_mid_out");
    checks++;
    if (upd.upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b want 1", upd.upd_ready);
    end
    rst = 1'b0;
    enable = 1'b0;
    upd.upd_valid = 1'b0;
    rq.delete();
    m_sh = '0;
    m_shdp = '0;
    m_full = 1'b0;
    @(negedge clk);
    check_off("rst_mid_idle");
    start_scan();
    for (int i = 0; i < PER; i++) begin
      if (m_c == 2) begin
        checks++;
        if (segments !== 7'h3F) begin
          errors++;
          $display("FAIL rst_mid_clear: got seg=%h want 3F", segments);
        end
      end
      scan_cycle(0, 0);
    end
    go_idle();
  endtask

  task automatic test_random();
    idle_update(16'($urandom), 4'($urandom));
    start_scan();
    for (int i = 0; i < 8 * PER; i++) scan_cycle(10, 16);
    go_idle();
    lzb_en = 1'b0;
  endtask

  initial begin
    upd.upd_valid  = 1'b0;
    upd.upd_digits = '0;
    upd.upd_dp     = '0;
    m_c = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_lzb();
    test_midframe();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
